// File: rtl/msk_tweakey_pkg.sv
// Shared definitions for the masked SKINNY tweakey schedule: cell permutation,
// LFSRs for TK2/TK3, bit-slice index helpers and the scheduler FSM states.
package msk_tweakey_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tk_state_e;

  localparam int LANE_TK1 = 0;
  localparam int LANE_TK2 = 1;
  localparam int LANE_TK3 = 2;

  // new cell i = old cell PT[i]
  localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  function automatic logic [7:0] lfsr_tk2_8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  function automatic logic [7:0] lfsr_tk3_8(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  function automatic logic [3:0] lfsr_tk2_4(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  function automatic logic [3:0] lfsr_tk3_4(input logic [3:0] x);
    return {x[0] ^ x[3], x[3:1]};
  endfunction

  // LSB of cell j inside one word; cell 0 is the most significant
  function automatic int cell_lsb(input int j, input int cell_w, input int d);
    return (15 - j) * cell_w * d;
  endfunction

  function automatic int word_lsb(input int w, input int cell_w, input int d);
    return w * 16 * cell_w * d;
  endfunction

  // LSB of the refresh mask for share s (1..d-1) of cell j in word w
  function automatic int rnd_lsb(input int w, input int j, input int s,
                                 input int cell_w, input int d);
    return (w * 16 + 15 - j) * cell_w * (d - 1) + (s - 1) * cell_w;
  endfunction

endpackage

// File: rtl/msk_tk_lane.sv
// One tweakey word's round function: cell permutation followed by the lane's
// LFSR on cells 0..7, applied independently to every share.
module msk_tk_lane
  import msk_tweakey_pkg::*;
#(
  parameter int CELL_W = 8,
  parameter int d      = 2,
  parameter int LANE   = LANE_TK1
) (
  input  logic [16*CELL_W*d-1:0] word_i,
  output logic [16*CELL_W*d-1:0] word_o
);

  for (genvar i = 0; i < 16; i++) begin : g_cell
    for (genvar s = 0; s < d; s++) begin : g_share
      localparam int DST = cell_lsb(i, CELL_W, d) + s * CELL_W;
      localparam int SRC = cell_lsb(PT[i], CELL_W, d) + s * CELL_W;
      logic [CELL_W-1:0] x;
      assign x = word_i[SRC +: CELL_W];

      if (i >= 8 || LANE == LANE_TK1) begin : g_pass
        assign word_o[DST +: CELL_W] = x;
      end else if (CELL_W == 8) begin : g_w8
        if (LANE == LANE_TK2) begin : g_tk2
          assign word_o[DST +: CELL_W] = lfsr_tk2_8(x);
        end else begin : g_tk3
          assign word_o[DST +: CELL_W] = lfsr_tk3_8(x);
        end
      end else begin : g_w4
        if (LANE == LANE_TK2) begin : g_tk2
          assign word_o[DST +: CELL_W] = lfsr_tk2_4(x);
        end else begin : g_tk3
          assign word_o[DST +: CELL_W] = lfsr_tk3_4(x);
        end
      end
    end
  end

endmodule

// File: rtl/msk_tweakey_sched.sv
// Masked SKINNY tweakey-schedule engine: load a d-share tweakey, stream NR round
// tweakeys under valid/ready. Optional share refresh: define MSK_TK_REFRESH_EN.
module msk_tweakey_sched
  import msk_tweakey_pkg::*;
#(
  parameter int d      = 2,
  parameter int Z      = 3,
  parameter int CELL_W = 8,
  parameter int NR     = 56
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [Z*16*CELL_W*d-1:0]      tk_i,
`ifdef MSK_TK_REFRESH_EN
  input  logic [Z*16*CELL_W*(d-1)-1:0]  rnd_i,
`endif
  output logic                          rtk_valid_o,
  input  logic                          rtk_ready_i,
  output logic [8*CELL_W*d-1:0]         rtk_o,
  output logic [$clog2(NR+1)-1:0]       round_o,
  output logic                          done_o,
  output logic [Z*16*CELL_W*d-1:0]      tk_final_o
);

  localparam int WORD_W = 16 * CELL_W * d;
  localparam int TK_W   = Z * WORD_W;
  localparam int RTK_W  = 8 * CELL_W * d;
  localparam int RW     = $clog2(NR + 1);

  tk_state_e         state_q, state_d;
  logic [RW-1:0]     round_q, round_d;
  logic [TK_W-1:0]   tk_q, tk_d;
  logic [TK_W-1:0]   tk_upd;
  logic [TK_W-1:0]   tk_step;

  for (genvar w = 0; w < Z; w++) begin : g_lane
    msk_tk_lane #(
      .CELL_W (CELL_W),
      .d      (d),
      .LANE   (w)
    ) u_lane (
      .word_i (tk_q[w*WORD_W +: WORD_W]),
      .word_o (tk_upd[w*WORD_W +: WORD_W])
    );
  end

`ifdef MSK_TK_REFRESH_EN
  // Each mask r_s lands on share s and on share 0, so the XOR of shares is unchanged.
  logic [CELL_W-1:0] r;
  always_comb begin
    tk_step = tk_upd;
    r       = '0;
    for (int w = 0; w < Z; w++) begin
      for (int j = 0; j < 16; j++) begin
        for (int s = 1; s < d; s++) begin
          r = rnd_i[rnd_lsb(w, j, s, CELL_W, d) +: CELL_W];
          tk_step[word_lsb(w, CELL_W, d) + cell_lsb(j, CELL_W, d) + s*CELL_W +: CELL_W] =
            tk_step[word_lsb(w, CELL_W, d) + cell_lsb(j, CELL_W, d) + s*CELL_W +: CELL_W] ^ r;
          tk_step[word_lsb(w, CELL_W, d) + cell_lsb(j, CELL_W, d) +: CELL_W] =
            tk_step[word_lsb(w, CELL_W, d) + cell_lsb(j, CELL_W, d) +: CELL_W] ^ r;
        end
      end
    end
  end
`else
  assign tk_step = tk_upd;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    tk_d         = tk_q;
    load_ready_o = 1'b0;
    rtk_valid_o  = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          tk_d    = tk_i;
          round_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rtk_valid_o = 1'b1;
        if (rtk_ready_i) begin
          if (round_q == RW'(NR - 1)) begin
            state_d = ST_DONE;
          end else begin
            tk_d    = tk_step;
            round_d = round_q + RW'(1);
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the tweakey register is reset too, because tk_final_o must read zero
  // after reset and must not leak shares from a previous run.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      tk_q    <= tk_d;
    end
  end

  // Sharewise XOR over words is linear, so shares never mix.
  always_comb begin
    rtk_o = '0;
    for (int w = 0; w < Z; w++) begin
      rtk_o = rtk_o ^ tk_q[w*WORD_W + RTK_W +: RTK_W];
    end
  end

  assign round_o    = round_q;
  assign tk_final_o = tk_q;

endmodule
